// File: rtl/ex_div_sequencer_if.sv
// EX-stage divide sequencer bus: operands and control in, stall/result out.
// master = EX pipeline side, slave = divide sequencer.
interface ex_div_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [4:0]      rd_in;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, flush, funct3, rs1_data, rs2_data, rd_in,
    input  stall, busy, done, result, rd_out
  );

  modport slave (
    input  start, flush, funct3, rs1_data, rs2_data, rd_in,
    output stall, busy, done, result, rd_out
  );
endinterface

// File: rtl/ex_div_sequencer.sv
// Iterative radix-2 shift-subtract sequencer for RV32M DIV/DIVU/REM/REMU.
// Holds the pipeline with stall while iterating; returns one registered result.
//
// state | meaning
// IDLE  | waiting for a divide-class op
// CALC  | one restoring-division iteration per cycle, XLEN cycles
// FIX   | sign correction and quotient/remainder select
// DONE  | result valid for one cycle, pipeline released
module ex_div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  ex_div_sequencer_if.slave   bus
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST_IT = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] part_q, part_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic            rem_sel_q, rem_sel_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rd_out_q, rd_out_d;

  logic            accept;
  logic            is_signed;
  logic            div_zero;
  logic            ovf;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] special_res;
  logic [XLEN:0]   part_shift;
  logic            ge;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    part_d      = part_q;
    quo_d       = quo_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    rem_sel_d   = rem_sel_q;
    rd_d        = rd_q;
    result_d    = result_q;
    rd_out_d    = rd_out_q;

    accept      = (state_q == IDLE) && bus.start && bus.funct3[2] && !bus.flush;
    is_signed   = !bus.funct3[0];
    div_zero    = (bus.rs2_data == '0);
    ovf         = is_signed && (bus.rs1_data == MIN_NEG) && (bus.rs2_data == '1);
    a_mag       = (is_signed && bus.rs1_data[XLEN-1]) ? -bus.rs1_data : bus.rs1_data;
    b_mag       = (is_signed && bus.rs2_data[XLEN-1]) ? -bus.rs2_data : bus.rs2_data;
    special_res = bus.funct3[1] ? (div_zero ? bus.rs1_data : '0)
                                : (div_zero ? '1 : MIN_NEG);

    // A set carry-out bit means the shifted value already exceeds any XLEN-bit divisor.
    part_shift  = {part_q, dvd_q[XLEN-1]};
    ge          = part_shift[XLEN] || (part_shift[XLEN-1:0] >= dvs_q);
    quo_fix     = neg_quo_q ? -quo_q : quo_q;
    rem_fix     = neg_rem_q ? -part_q : part_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          rd_d      = bus.rd_in;
          rem_sel_d = bus.funct3[1];
          neg_quo_d = is_signed && (bus.rs1_data[XLEN-1] ^ bus.rs2_data[XLEN-1]);
          neg_rem_d = is_signed && bus.rs1_data[XLEN-1];
          if (div_zero || ovf) begin
            result_d = special_res;
            rd_out_d = bus.rd_in;
            state_d  = DONE;
          end else begin
            dvd_d   = a_mag;
            dvs_d   = b_mag;
            part_d  = '0;
            quo_d   = '0;
            cnt_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          part_d = ge ? (part_shift[XLEN-1:0] - dvs_q) : part_shift[XLEN-1:0];
          quo_d  = {quo_q[XLEN-2:0], ge};
          dvd_d  = {dvd_q[XLEN-2:0], 1'b0};
          if (cnt_q == LAST_IT) begin
            state_d = FIX;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FIX: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          result_d = rem_sel_q ? rem_fix : quo_fix;
          rd_out_d = rd_q;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      part_q    <= '0;
      quo_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rem_sel_q <= 1'b0;
      rd_q      <= '0;
      result_q  <= '0;
      rd_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      part_q    <= part_d;
      quo_q     <= quo_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      rem_sel_q <= rem_sel_d;
      rd_q      <= rd_d;
      result_q  <= result_d;
      rd_out_q  <= rd_out_d;
    end
  end

  // Stall is released in DONE so the pipeline captures result/rd_out that cycle.
  assign bus.stall  = accept || (((state_q == CALC) || (state_q == FIX)) && !bus.flush);
  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE) && !bus.flush;
  assign bus.result = result_q;
  assign bus.rd_out = rd_out_q;

endmodule
